alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 Parameter SEL_W, default 3, ALU opcode width.
REQ-003 The clock is clk; reset is rst_n, asynchronous and active-low; there is exactly one clock.
REQ-004 Ports SHALL be:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 req0_valid  in  1  requester 0 has an operation
 req0_ready  out  1  requester 0 operation accepted this cycle
 req0_sel  in  3  requester 0 opcode
 req0_a  in  8  requester 0 operand A
 req0_b  in  8  requester 0 operand B
 req1_valid, req1_ready, req1_sel, req1_a, req1_b  same as requester 0, for requester 1
 rsp_valid  out  1  result available
 rsp_ready  in  1  consumer takes result
 rsp_id  out  1  requester that owns the result
 rsp_data  out  8  ALU result
 rsp_c  out  1  carry/borrow flag
 rsp_z  out  1  zero flag
 alu_en  out  1  ALU enable
 alu_sel  out  3  ALU opcode
 alu_a  out  8  ALU operand A
 alu_b  out  8  ALU operand B
 alu_out  in  8  ALU result; tri-stated by the ALU when alu_en=0

Function
REQ-005 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-006 IDLE: if neither valid is asserted, stay in IDLE; otherwise grant one requester, assert its reqN_ready combinationally for that cycle only, latch sel/a/b and the id into internal registers, and go to EXEC.
REQ-007 Arbitration: round-robin with a 1-bit priority pointer. When both requests are valid, grant the pointer's requester. After each grant, the pointer points to the other requester. The pointer resets to 0.
REQ-008 reqN_ready SHALL be 0 in every state except IDLE.
REQ-009 EXEC lasts exactly one cycle.
 - alu_en=1; alu_sel/alu_a/alu_b driven from the latched registers.
 - alu_out is registered into rsp_data at the end of the cycle.
 - Next state is RESP.
REQ-010 Outside EXEC: alu_en=0, alu_sel=000, alu_a=0, alu_b=0; alu_out is never sampled.
REQ-011 rsp_c is computed from the latched operands, as a 9-bit extension:
 - 000: carry out of a+b.
 - 001: borrow, i.e. a<b unsigned.
 - 111: b==8'hFF.
 - all other opcodes: 0.
REQ-012 rsp_z = (registered alu_out == 0), computed for every opcode.
REQ-013 RESP: rsp_valid=1, and rsp_id/rsp_data/rsp_c/rsp_z are held stable until rsp_valid&&rsp_ready; on that cycle go to IDLE.
REQ-014 Latency: accept (cycle 0) -> rsp_valid (cycle 2). Minimum issue interval is 3 cycles when rsp_ready is held high.
REQ-015 A requester may drop valid before ready without error; nothing is latched for it.
REQ-016 A request that arrives while the FSM is busy is not accepted until the next IDLE cycle; requests are never lost or duplicated.
REQ-017 rsp_data/rsp_c/rsp_z keep their last values when rsp_valid=0.

Reset
REQ-018 While rst_n=0:
 - state=IDLE, pointer=0.
 - all outputs 0: ready, rsp_*, alu_en, alu_sel, alu_a, alu_b.
REQ-019 Asserting reset in EXEC or RESP aborts the operation; no response is ever issued for it.
REQ-020 The first grant can occur in the first clk edge after rst_n deasserts.

Structure
REQ-021 Shared package alu_pkg holds:
 - opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_NOT=101, ALU_PASSB=110, ALU_INCB=111.
 - the FSM state encoding.
 - the DATA_W default.
REQ-022 One sub-module, rr_arb2: 2-input round-robin grant logic with the pointer register; alu_arbiter instantiates it once.

Verification
REQ-023 Single add: req0 sel=000 a=8'hF0 b=8'h20, rsp_ready=1 -> ready0 in cycle 0, alu_en=1 in cycle 1 only, rsp_valid in cycle 2 with id=0, data=8'h10, c=1, z=0.
REQ-024 Contention: both valid every cycle after reset, 4 operations -> grant order 0,1,0,1; each accept 3 cycles apart.
REQ-025 Subtract to zero: req1 sel=001 a=8'h05 b=8'h05 -> data=8'h00, z=1, c=0; then a=8'h03 b=8'h05 -> data=8'hFE, c=1.
REQ-026 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, ready0/1=0, alu_en=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-027 Reset in EXEC: assert rst_n=0 mid-EXEC -> all outputs 0 immediately, no rsp_valid afterwards; pointer=0, so req0 wins the first contended grant.
REQ-028 Increment wrap: sel=111 b=8'hFF -> data=8'h00, c=1, z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states, default widths.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned SEL_W_DEFAULT  = 3;

  localparam logic [SEL_W_DEFAULT-1:0] ALU_ADD   = 3'b000;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_SUB   = 3'b001;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_AND   = 3'b010;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_OR    = 3'b011;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_XOR   = 3'b100;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_NOT   = 3'b101;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_PASSB = 3'b110;
  localparam logic [SEL_W_DEFAULT-1:0] ALU_INCB  = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a 1-bit priority pointer.
// The pointer moves to the non-granted requester whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && (|req_i)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU, one operation in flight at a time.
// IDLE grants and latches, EXEC drives the ALU for one cycle, RESP holds the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned SEL_W  = SEL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_c,
  output logic              rsp_z,
  output logic              alu_en,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_c_q, rsp_c_d, rsp_z_q, rsp_z_d;
  logic [1:0]        req_valid, gnt;
  logic              accept;
  logic [DATA_W:0]   sum_ext;
  logic              carry;

  assign req_valid = {req1_valid, req0_valid};
  assign accept    = (state_q == StIdle) && (|req_valid);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .en_i  (accept),
    .gnt_o (gnt)
  );

  // Gated by rst_n so no handshake is offered while reset is held.
  assign req0_ready = rst_n & accept & gnt[0];
  assign req1_ready = rst_n & accept & gnt[1];

  // Flag is derived from the latched operands, not from the ALU result.
  always_comb begin
    carry   = 1'b0;
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    case (sel_q)
      ALU_ADD:  carry = sum_ext[DATA_W];
      ALU_SUB:  carry = (a_q < b_q);
      ALU_INCB: carry = &b_q;
      default:  carry = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_c_d    = rsp_c_q;
    rsp_z_d    = rsp_z_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          id_d    = gnt[1];
          sel_d   = gnt[1] ? req1_sel : req0_sel;
          a_d     = gnt[1] ? req1_a : req0_a;
          b_d     = gnt[1] ? req1_b : req0_b;
        end
      end
      StExec: begin
        state_d    = StResp;
        rsp_data_d = alu_out;
        rsp_c_d    = carry;
        rsp_z_d    = (alu_out == '0);
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_c_q    <= 1'b0;
      rsp_z_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_c_q    <= rsp_c_d;
      rsp_z_q    <= rsp_z_d;
    end
  end

  assign alu_en    = (state_q == StExec);
  assign alu_sel   = alu_en ? sel_q : '0;
  assign alu_a     = alu_en ? a_q : '0;
  assign alu_b     = alu_en ? b_q : '0;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives alu_out, and a
// scoreboard queue holds expected responses pushed at accept time.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_sel, req1_sel;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_c, rsp_z;
  logic [7:0] rsp_data;
  logic       alu_en;
  logic [2:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_out;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       c;
    logic       z;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_c      (rsp_c),
    .rsp_z      (rsp_z),
    .alu_en     (alu_en),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out)
  );

  function automatic rsp_t model(input logic id, input logic [2:0] sel,
                                 input logic [7:0] a, input logic [7:0] b);
    rsp_t       r;
    logic [8:0] w;
    r.id = id;
    r.c  = 1'b0;
    w    = {1'b0, a} + {1'b0, b};
    case (sel)
      3'd0: begin r.data = w[7:0]; r.c = w[8]; end
      3'd1: begin r.data = a - b; r.c = (a < b); end
      3'd2: r.data = a & b;
      3'd3: r.data = a | b;
      3'd4: r.data = a ^ b;
      3'd5: r.data = ~a;
      3'd6: r.data = b;
      default: begin r.data = b + 8'd1; r.c = (b == 8'hFF); end
    endcase
    r.z = (r.data == 8'h00);
    return r;
  endfunction

  // Junk value when disabled stands in for the floating bus; sampling it would corrupt data.
  always_comb begin
    alu_out = 8'hA5;
    if (alu_en) alu_out = model(1'b0, alu_sel, alu_a, alu_b).data;
  end

  task automatic set_req(input logic id, input logic v, input logic [2:0] sel,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_sel = sel; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_sel = sel; req0_a = a; req0_b = b;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, ALU_ADD, 8'h11, 8'h22);
    set_req(1'b1, 1'b1, ALU_SUB, 8'h33, 8'h44);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_rsp: got v=%b id=%b d=%h c=%b z=%b required all 0",
               rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z);
    end
    n_cmp++;
    if ({alu_en, alu_sel, alu_a, alu_b} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_alu: got en=%b sel=%h a=%h b=%h required all 0",
               alu_en, alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // One full transaction with optional response backpressure of `hold` cycles.
  task automatic do_op(input logic id, input logic [2:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input int hold);
    rsp_t got, exp, snap;
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(id, 1'b1, sel, a, b);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL op_accept: got ready1/0=%b required %b", {req1_ready, req0_ready},
               id ? 2'b10 : 2'b01);
    end
    sb_q.push_back(model(id, sel, a, b));
    @(negedge clk);
    set_req(id, 1'b0, sel, a, b);
    #1;
    n_cmp++;
    if ({alu_en, alu_sel, alu_a, alu_b, rsp_valid} !== {1'b1, sel, a, b, 1'b0}) begin
      n_err++;
      $display("FAIL op_exec: got en=%b sel=%h a=%h b=%h rv=%b required en=1 sel=%h a=%h b=%h rv=0",
               alu_en, alu_sel, alu_a, alu_b, rsp_valid, sel, a, b);
    end
    snap = '0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      rsp_ready = (i == hold);
      if (id) req0_valid = (i < hold);
      else    req1_valid = (i < hold);
      #1;
      got = {rsp_id, rsp_data, rsp_c, rsp_z};
      if (i == 0) snap = got;
      n_cmp++;
      if ({rsp_valid, req0_ready, req1_ready, alu_en} !== 4'b1000 || (i > 0 && got !== snap)) begin
        n_err++;
        $display("FAIL op_resp_hold cyc %0d: got v/r0/r1/en=%b rsp=%h required 1000 rsp=%h",
                 i, {rsp_valid, req0_ready, req1_ready, alu_en}, got, snap);
      end
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL op_resp: got response %h required none pending", got);
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        n_err++;
        $display("FAIL op_resp: got id=%b d=%h c=%b z=%b required id=%b d=%h c=%b z=%b",
                 got.id, got.data, got.c, got.z, exp.id, exp.data, exp.c, exp.z);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL op_idle: got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_single_add();
    do_op(1'b0, ALU_ADD, 8'hF0, 8'h20, 0);
  endtask

  task automatic test_sub();
    do_op(1'b1, ALU_SUB, 8'h05, 8'h05, 0);
    do_op(1'b1, ALU_SUB, 8'h03, 8'h05, 0);
  endtask

  task automatic test_ops();
    do_op(1'b0, ALU_INCB, 8'h3C, 8'hFF, 0);
    do_op(1'b1, ALU_INCB, 8'h00, 8'h7F, 0);
    for (int k = 2; k <= 6; k++) begin
      do_op(k[0], 3'(k), 8'($urandom), 8'($urandom), 0);
    end
  endtask

  task automatic test_backpressure();
    do_op(1'b0, ALU_XOR, 8'h5A, 8'h0F, 5);
  endtask

  task automatic test_back_to_back();
    int   n_acc, n_rsp, last_acc;
    logic upd0, upd1, acc_id;
    rsp_t got, exp;
    n_acc = 0; n_rsp = 0; last_acc = 0; upd0 = 0; upd1 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, ALU_ADD, 8'h81, 8'h90);
    set_req(1'b1, 1'b1, ALU_SUB, 8'h10, 8'h20);
    for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (upd0) begin req0_a = 8'($urandom); req0_b = 8'($urandom); upd0 = 0; end
      if (upd1) begin req1_a = 8'($urandom); req1_b = 8'($urandom); upd1 = 0; end
      if (n_acc >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (req0_ready || req1_ready) begin
        acc_id = req1_ready;
        n_cmp++;
        if ((req0_ready && req1_ready) || acc_id !== n_acc[0] ||
            (n_acc > 0 && cyc - last_acc != 3)) begin
          n_err++;
          $display("FAIL b2b_grant %0d: got id=%b both=%b gap=%0d required id=%b gap=3",
                   n_acc, acc_id, req0_ready && req1_ready, cyc - last_acc, n_acc[0]);
        end
        if (acc_id) sb_q.push_back(model(1'b1, req1_sel, req1_a, req1_b));
        else        sb_q.push_back(model(1'b0, req0_sel, req0_a, req0_b));
        upd0 = !acc_id;
        upd1 = acc_id;
        last_acc = cyc;
        n_acc++;
      end
      if (rsp_valid) begin
        got = {rsp_id, rsp_data, rsp_c, rsp_z};
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : ~got;
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL b2b_resp %0d: got %h required %h", n_rsp, got, exp);
        end
        n_rsp++;
      end
    end
    n_cmp++;
    if (n_rsp != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d responses required 4", n_rsp);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_exec();
    int   n_rsp;
    rsp_t got, exp;
    n_rsp = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(1'b0, 1'b1, ALU_ADD, 8'h01, 8'h02);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rexec_accept: got ready0=%b required 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_c, rsp_z,
         alu_en, alu_sel, alu_a, alu_b} !== 34'h0) begin
      n_err++;
      $display("FAIL rexec_outputs: got en=%b sel=%h a=%h b=%h rv=%b d=%h required all 0",
               alu_en, alu_sel, alu_a, alu_b, rsp_valid, rsp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, ALU_OR, 8'h0C, 8'h30);
    set_req(1'b1, 1'b1, ALU_AND, 8'hFF, 8'h0F);
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rexec_ptr: got ready1/0=%b required 01", {req1_ready, req0_ready});
    end
    sb_q.push_back(model(1'b0, ALU_OR, 8'h0C, 8'h30));
    for (int cyc = 1; cyc < 8; cyc++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      if (rsp_valid) begin
        got = {rsp_id, rsp_data, rsp_c, rsp_z};
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : ~got;
        n_cmp++;
        if (got !== exp || cyc != 2) begin
          n_err++;
          $display("FAIL rexec_resp: got %h at cycle %0d required %h at cycle 2", got, cyc, exp);
        end
        n_rsp++;
      end
    end
    n_cmp++;
    if (n_rsp != 1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL rexec_count: got %0d responses, %0d pending required 1, 0",
               n_rsp, sb_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    test_reset();
    test_single_add();
    test_sub();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
